gpr_wport_arb: RTL and testbench

Write-port arbiter and scoreboard for the 32x32 general-purpose register file. It shares the file's single write port (address, data, write enable) between two requesters: the in-order pipeline writeback and a late-result requester, such as load returns or multi-cycle unit results. Late results are buffered in a 2-entry FIFO. The block reports read-after-write hazards against buffered results and forces a pipeline stall to prevent starvation.

---
 rtl/gpr_wport_arb.sv | 192 +++++++++++++++++++
 tb/tb_gpr_wport_arb.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wport_arb.sv
// gpr_wport_arb: shares the single GPR write port between the in-order
// pipeline writeback and a late-result requester buffered in a 2-entry FIFO.
// Tracks read-after-write hazards against buffered entries, kills buffered
// entries overwritten by a younger pipeline write, and forces a starved FIFO
// head onto the port by stalling the pipeline for one cycle.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   wb_we/addr/data     pipeline writeback request
//   wb_stall            pipeline write not granted this cycle
//   lr_valid/addr/data  late-result request, accepted when lr_ready
//   lr_ready            FIFO has space (no pass-through)
//   rd_a1, rd_a2        decode read addresses
//   hazard1, hazard2    read address has a buffered, unkilled write pending
//   gpr_we/wa/wd        register file write port (combinational, commits at edge)
//   fifo_cnt            FIFO occupancy 0..2
module gpr_wport_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        lr_valid,
  input  logic [4:0]  lr_addr,
  input  logic [31:0] lr_data,
  output logic        lr_ready,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        gpr_we,
  output logic [4:0]  gpr_wa,
  output logic [31:0] gpr_wd,
  output logic [1:0]  fifo_cnt
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned AGE_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              kill;
  } entry_t;

  // FIFO storage and bookkeeping
  entry_t           mem [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       cnt;
  logic [AGE_W-1:0] age;

  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] kill_hit;
  entry_t           head;
  logic             head_valid;
  logic             head_live;
  logic             age_full;
  logic             wb_req;
  logic             force_g;
  logic             primary_g;
  logic             late_g;
  logic             pop;
  logic             push;
  logic             space;
  logic [AGE_W-1:0] age_nxt;
  logic             hit1;
  logic             hit2;

  // Which physical slots hold a stored entry
  always_comb begin
    slot_valid = '0;
    if (cnt == 2'd2) begin
      slot_valid = '1;
    end else if (cnt == 2'd1) begin
      slot_valid[rd_ptr] = 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (cnt != 2'd0);
  assign head_live  = head_valid && !head.kill;
  assign age_full   = (age == AGE_W'(STARVE_MAX));
  assign wb_req     = wb_we && (wb_addr != '0);

  // Grant priority: starved head, then pipeline, then waiting head
  assign force_g   = head_live && age_full;
  assign primary_g = !force_g && wb_req;
  assign late_g    = !force_g && !wb_req && head_live;

  // A killed head is discarded without touching the port
  assign pop   = force_g || late_g || (head_valid && head.kill);
  assign space = (cnt != 2'd2);
  assign push  = lr_valid && space && (lr_addr != '0);

  // A pipeline write to X makes older buffered writes to X obsolete
  always_comb begin
    kill_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_hit[i] = primary_g && slot_valid[i] && (mem[i].addr == wb_addr);
    end
  end

  // Age of the head: counts waiting cycles, saturates at the force threshold
  always_comb begin
    age_nxt = age;
    if (!head_valid || pop) begin
      age_nxt = '0;
    end else if (!age_full) begin
      age_nxt = age + AGE_W'(1);
    end
  end

  // State update
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
      age    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_hit[i]) begin
          mem[i].kill <= 1'b1;
        end
      end
      if (push) begin
        mem[wr_ptr] <= '{addr: lr_addr, data: lr_data, kill: 1'b0};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      age <= age_nxt;
    end
  end

  // Write port drive; address and data are zero when idle
  always_comb begin
    gpr_we   = 1'b0;
    gpr_wa   = '0;
    gpr_wd   = '0;
    wb_stall = 1'b0;
    if (reset) begin
      if (force_g) begin
        gpr_we   = 1'b1;
        gpr_wa   = head.addr;
        gpr_wd   = head.data;
        wb_stall = wb_req;
      end else if (primary_g) begin
        gpr_we = 1'b1;
        gpr_wa = wb_addr;
        gpr_wd = wb_data;
      end else if (late_g) begin
        gpr_we = 1'b1;
        gpr_wa = head.addr;
        gpr_wd = head.data;
      end
    end
  end

  // RAW hazard lookup against stored, unkilled entries only
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && !mem[i].kill) begin
        if (mem[i].addr == rd_a1) hit1 = 1'b1;
        if (mem[i].addr == rd_a2) hit2 = 1'b1;
      end
    end
  end

  assign hazard1  = reset && (rd_a1 != '0) && hit1;
  assign hazard2  = reset && (rd_a2 != '0) && hit2;
  assign lr_ready = reset && space;
  assign fifo_cnt = reset ? cnt : 2'd0;

endmodule

// File: tb/tb_gpr_wport_arb.sv
module tb_gpr_wport_arb;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        lr_valid;
  logic [4:0]  lr_addr;
  logic [31:0] lr_data;
  logic        lr_ready;
  logic [4:0]  rd_a1;
  logic [4:0]  rd_a2;
  logic        hazard1;
  logic        hazard2;
  logic        gpr_we;
  logic [4:0]  gpr_wa;
  logic [31:0] gpr_wd;
  logic [1:0]  fifo_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf [32];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  gpr_wport_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .lr_valid(lr_valid), .lr_addr(lr_addr), .lr_data(lr_data), .lr_ready(lr_ready),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .hazard1(hazard1), .hazard2(hazard2),
    .gpr_we(gpr_we), .gpr_wa(gpr_wa), .gpr_wd(gpr_wd), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  // Register file sink fed by the write port
  always @(posedge clk) if (gpr_we) rf[gpr_wa] <= gpr_wd;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic set_in(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
    wb_we = wwe; wb_addr = wa; wb_data = wd;
    lr_valid = lv; lr_addr = la; lr_data = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rd_a1 = 5'd0; rd_a2 = 5'd0;
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'h9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (gpr_we !== 1'b0 || lr_ready !== 1'b0 || fifo_cnt !== 2'd0 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got we=%b ready=%b cnt=%0d stall=%b, expected 0 0 0 0",
               gpr_we, lr_ready, fifo_cnt, wb_stall);
    end
    next_cycle();
    reset = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++;
    if (lr_ready !== 1'b1 || fifo_cnt !== 2'd0 || gpr_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b cnt=%0d we=%b, expected 1 0 0",
               lr_ready, fifo_cnt, gpr_we);
    end
    // Buffer two entries behind pipeline traffic, then reset mid-operation
    next_cycle();
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h44);
    next_cycle();
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd6, 32'h66);
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 2'd1) begin
      errors++;
      $display("FAIL midreset_fill: got cnt=%0d, expected 1", fifo_cnt);
    end
    next_cycle();
    reset = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++;
    if (gpr_we !== 1'b0 || fifo_cnt !== 2'd0 || lr_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_low: got we=%b cnt=%0d ready=%b, expected 0 0 0",
               gpr_we, fifo_cnt, lr_ready);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (gpr_we !== 1'b0 || fifo_cnt !== 2'd0) begin
      errors++;
      $display("FAIL midreset_discard: got we=%b cnt=%0d, expected 0 0", gpr_we, fifo_cnt);
    end
    next_cycle();
  endtask

  task automatic test_uncontended();
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hDEADBEEF);
    rd_a1 = 5'd9;
    @(negedge clk);
    checks++;
    if (hazard1 !== 1'b0 || gpr_we !== 1'b0 || lr_ready !== 1'b1) begin
      errors++;
      $display("FAIL unc_accept: got hz1=%b we=%b ready=%b, expected 0 0 1", hazard1, gpr_we, lr_ready);
    end
    next_cycle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++;
    if (gpr_we !== 1'b1 || gpr_wa !== 5'd9 || gpr_wd !== 32'hDEADBEEF || hazard1 !== 1'b1 || fifo_cnt !== 2'd1) begin
      errors++;
      $display("FAIL unc_write: got we=%b wa=%0d wd=%h hz1=%b cnt=%0d, expected 1 9 deadbeef 1 1",
               gpr_we, gpr_wa, gpr_wd, hazard1, fifo_cnt);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (gpr_we !== 1'b0 || gpr_wa !== 5'd0 || gpr_wd !== 32'd0 || hazard1 !== 1'b0 || fifo_cnt !== 2'd0) begin
      errors++;
      $display("FAIL unc_after: got we=%b wa=%0d wd=%h hz1=%b cnt=%0d, expected 0 0 0 0 0",
               gpr_we, gpr_wa, gpr_wd, hazard1, fifo_cnt);
    end
    rd_a1 = 5'd0;
    next_cycle();
  endtask

  task automatic test_starve();
    set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd5, 32'h55);
    @(negedge clk);
    checks++;
    if (gpr_wa !== 5'd3 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL starve_push: got wa=%0d stall=%b, expected 3 0", gpr_wa, wb_stall);
    end
    next_cycle();
    set_in(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    for (int c = 0; c < SM; c++) begin
      @(negedge clk);
      checks++;
      if (gpr_we !== 1'b1 || gpr_wa !== 5'd3 || wb_stall !== 1'b0) begin
        errors++;
        $display("FAIL starve_wait%0d: got we=%b wa=%0d stall=%b, expected 1 3 0",
                 c, gpr_we, gpr_wa, wb_stall);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (gpr_we !== 1'b1 || gpr_wa !== 5'd5 || gpr_wd !== 32'h55 || wb_stall !== 1'b1) begin
      errors++;
      $display("FAIL starve_force: got we=%b wa=%0d wd=%h stall=%b, expected 1 5 55 1",
               gpr_we, gpr_wa, gpr_wd, wb_stall);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (gpr_wa !== 5'd3 || wb_stall !== 1'b0 || fifo_cnt !== 2'd0) begin
      errors++;
      $display("FAIL starve_resume: got wa=%0d stall=%b cnt=%0d, expected 3 0 0",
               gpr_wa, wb_stall, fifo_cnt);
    end
    next_cycle();
  endtask

  task automatic test_full();
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd10, 32'hA);
    next_cycle();
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd11, 32'hB);
    next_cycle();
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hC);
    @(negedge clk);
    checks++;
    if (lr_ready !== 1'b0 || fifo_cnt !== 2'd2) begin
      errors++;
      $display("FAIL full_block: got ready=%b cnt=%0d, expected 0 2", lr_ready, fifo_cnt);
    end
    next_cycle();
    // Pop while full: the push is still refused
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC);
    @(negedge clk);
    checks++;
    if (gpr_wa !== 5'd10 || lr_ready !== 1'b0 || fifo_cnt !== 2'd2) begin
      errors++;
      $display("FAIL full_pop: got wa=%0d ready=%b cnt=%0d, expected 10 0 2", gpr_wa, lr_ready, fifo_cnt);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (gpr_wa !== 5'd11 || lr_ready !== 1'b1 || fifo_cnt !== 2'd1) begin
      errors++;
      $display("FAIL full_nopass: got wa=%0d ready=%b cnt=%0d, expected 11 1 1", gpr_wa, lr_ready, fifo_cnt);
    end
    next_cycle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 2'd1 || gpr_wa !== 5'd12 || gpr_wd !== 32'hC) begin
      errors++;
      $display("FAIL pushpop_cnt: got cnt=%0d wa=%0d wd=%h, expected 1 12 c", fifo_cnt, gpr_wa, gpr_wd);
    end
    next_cycle();
  endtask

  task automatic test_waw();
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd7, 32'h77);
    next_cycle();
    set_in(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0);
    rd_a1 = 5'd7;
    @(negedge clk);
    checks++;
    if (hazard1 !== 1'b1 || gpr_wa !== 5'd7 || gpr_wd !== 32'h11) begin
      errors++;
      $display("FAIL waw_before: got hz1=%b wa=%0d wd=%h, expected 1 7 11", hazard1, gpr_wa, gpr_wd);
    end
    next_cycle();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++;
    if (hazard1 !== 1'b0 || gpr_we !== 1'b0 || fifo_cnt !== 2'd1) begin
      errors++;
      $display("FAIL waw_drop: got hz1=%b we=%b cnt=%0d, expected 0 0 1", hazard1, gpr_we, fifo_cnt);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 2'd0 || rf[7] !== 32'h11) begin
      errors++;
      $display("FAIL waw_reg: got cnt=%0d r7=%h, expected 0 11", fifo_cnt, rf[7]);
    end
    rd_a1 = 5'd0;
    next_cycle();
  endtask

  task automatic test_zero();
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF);
    @(negedge clk);
    checks++;
    if (lr_ready !== 1'b1 || gpr_we !== 1'b0) begin
      errors++;
      $display("FAIL zero_lr_accept: got ready=%b we=%b, expected 1 0", lr_ready, gpr_we);
    end
    next_cycle();
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd8, 32'h88);
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 2'd0) begin
      errors++;
      $display("FAIL zero_lr_cnt: got cnt=%0d, expected 0", fifo_cnt);
    end
    next_cycle();
    set_in(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++;
    if (gpr_we !== 1'b1 || gpr_wa !== 5'd8 || gpr_wd !== 32'h88 || wb_stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_wb_late: got we=%b wa=%0d wd=%h stall=%b, expected 1 8 88 0",
               gpr_we, gpr_wa, gpr_wd, wb_stall);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (gpr_we !== 1'b0 || wb_stall !== 1'b0 || fifo_cnt !== 2'd0) begin
      errors++;
      $display("FAIL zero_wb_idle: got we=%b stall=%b cnt=%0d, expected 0 0 0", gpr_we, wb_stall, fifo_cnt);
    end
    next_cycle();
  endtask

  // Random traffic against a queue-based model of the arbitration rules
  task automatic test_random();
    ent_t        q[$];
    int          age;
    int          sz;
    bit          rst, wbreq, frc, pop, e_we, e_stall, e_h1, e_h2;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    reset = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    next_cycle();
    q.delete();
    age = 0;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 59) != 0);
      reset = rst;
      set_in(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
      rd_a1 = 5'($urandom_range(0, 7));
      rd_a2 = 5'($urandom_range(0, 7));
      sz = q.size();
      wbreq = wb_we && (wb_addr != 5'd0);
      frc = (sz > 0) && !q[0].kill && (age >= SM);
      e_we = 0; e_wa = 5'd0; e_wd = 32'd0; e_stall = 0; pop = 0;
      if (frc) begin
        e_we = 1; e_wa = q[0].addr; e_wd = q[0].data; e_stall = wbreq; pop = 1;
      end else if (wbreq) begin
        e_we = 1; e_wa = wb_addr; e_wd = wb_data;
        pop = (sz > 0) && q[0].kill;
      end else if (sz > 0) begin
        pop = 1;
        if (!q[0].kill) begin
          e_we = 1; e_wa = q[0].addr; e_wd = q[0].data;
        end
      end
      e_h1 = 0; e_h2 = 0;
      foreach (q[k]) begin
        if (!q[k].kill && rd_a1 != 5'd0 && q[k].addr == rd_a1) e_h1 = 1;
        if (!q[k].kill && rd_a2 != 5'd0 && q[k].addr == rd_a2) e_h2 = 1;
      end
      if (!rst) begin
        e_we = 0; e_wa = 5'd0; e_wd = 32'd0; e_stall = 0; e_h1 = 0; e_h2 = 0;
      end
      @(negedge clk);
      checks++;
      if ({gpr_we, gpr_wa, gpr_wd} !== {e_we, e_wa, e_wd}) begin
        errors++;
        $display("FAIL rand_port c=%0d: got we=%b wa=%0d wd=%h, expected we=%b wa=%0d wd=%h",
                 c, gpr_we, gpr_wa, gpr_wd, e_we, e_wa, e_wd);
      end
      checks++;
      if (wb_stall !== e_stall) begin
        errors++;
        $display("FAIL rand_stall c=%0d: got %b, expected %b", c, wb_stall, e_stall);
      end
      checks++;
      if (lr_ready !== (rst && sz < 2) || fifo_cnt !== (rst ? 2'(sz) : 2'd0)) begin
        errors++;
        $display("FAIL rand_fifo c=%0d: got ready=%b cnt=%0d, expected ready=%b cnt=%0d",
                 c, lr_ready, fifo_cnt, (rst && sz < 2), (rst ? sz : 0));
      end
      checks++;
      if (hazard1 !== e_h1 || hazard2 !== e_h2) begin
        errors++;
        $display("FAIL rand_hazard c=%0d: got hz1=%b hz2=%b, expected hz1=%b hz2=%b",
                 c, hazard1, hazard2, e_h1, e_h2);
      end
      if (!rst) begin
        q.delete();
        age = 0;
      end else begin
        if (wbreq && !frc) foreach (q[k]) if (q[k].addr == wb_addr) q[k].kill = 1;
        if (sz == 0 || pop) age = 0;
        else if (age < SM) age++;
        if (pop) void'(q.pop_front());
        if (lr_valid && sz < 2 && lr_addr != 5'd0) begin
          ent_t e;
          e.addr = lr_addr; e.data = lr_data; e.kill = 0;
          q.push_back(e);
        end
      end
      next_cycle();
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_uncontended();
    test_starve();
    test_full();
    test_waw();
    test_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
